// File: rtl/sata_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sata_ctrl_pkg
// Brief    : Shared types and constants for the trn_c control transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package sata_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_DATA    = 3'd2,
        ST_WAIT_OK = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam logic [7:0] c_WORD0_TAG = 8'hC5;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] data;
    } evt_t;

    localparam int c_EVT_W = $bits(evt_t);

    function automatic logic [31:0] make_word0(input logic [3:0] code);
        return {c_WORD0_TAG, 20'h0, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_evt_fifo
// Brief    : Synchronous event FIFO with pointer/count bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_evt_fifo #(
    parameter int C_DEPTH = 4,
    parameter int C_WIDTH = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [C_WIDTH-1:0] i_din,
    input  logic               i_pop,
    output logic [C_WIDTH-1:0] o_dout,
    output logic               o_empty,
    output logic               o_full
);

    localparam int c_AW = $clog2(C_DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(C_DEPTH);

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               r_full;

    logic               w_push;
    logic               w_pop;
    logic [c_AW:0]      w_count_next;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Full is registered from the next count so it rises right after the filling push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CNT_FULL);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/sata_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module   : sata_ctrl_tx
// Brief    : Link-layer trn_c transmitter turning queued events into 2-word frames.
// Revision : 1.0 - initial release
// ============================================================================
module sata_ctrl_tx
    import sata_ctrl_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_TIMEOUT    = 1024
) (
    input  logic        phyclk,
    input  logic        phyreset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [3:0]  ev_code,
    input  logic [31:0] ev_data,
    output logic        trn_csof_n,
    output logic        trn_ceof_n,
    output logic [31:0] trn_cd,
    output logic        trn_csrc_rdy_n,
    output logic        trn_csrc_dsc_n,
    input  logic        trn_cdst_rdy_n,
    input  logic        trn_cdst_dsc_n,
    input  logic        trn_cdst_lock_n,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_timeout
);

    localparam int c_TMO_W = $clog2(C_TIMEOUT) + 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(C_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    evt_t                r_evt;
    evt_t                w_evt_next;
    evt_t                w_fifo_dout;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_pop;
    logic                w_ack;
    logic                w_ok;
    logic                w_tmo_hit;
    logic                w_waiting;
    logic                r_ok_seen;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                w_unused;

    logic                r_csof_n;
    logic                r_ceof_n;
    logic [31:0]         r_cd;
    logic                r_rdy_n;
    logic                r_dsc_n;
    logic                r_busy;
    logic                r_tx_done;
    logic                r_tx_timeout;

    assign w_ack     = ~trn_cdst_rdy_n;
    assign w_ok      = ~trn_cdst_dsc_n;
    assign w_unused  = trn_cdst_lock_n;
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
    assign w_waiting = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_WAIT_OK);

    ctrl_evt_fifo #(
        .C_DEPTH (C_FIFO_DEPTH),
        .C_WIDTH (c_EVT_W)
    ) u_fifo (
        .clk     (phyclk),
        .rst     (phyreset),
        .i_push  (ev_valid),
        .i_din   ({ev_code, ev_data}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign ev_ready = ~w_fifo_full;

    // Holding back one IDLE cycle after tx_done keeps back-to-back frames apart
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !r_tx_done) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_ack)          w_state_next = ST_DATA;
                else if (w_tmo_hit) w_state_next = ST_ABORT;
            end
            ST_DATA: begin
                if (w_ack)          w_state_next = ST_WAIT_OK;
                else if (w_tmo_hit) w_state_next = ST_ABORT;
            end
            ST_WAIT_OK: begin
                if (w_ok || r_ok_seen) w_state_next = ST_IDLE;
                else if (w_tmo_hit)    w_state_next = ST_ABORT;
            end
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_evt_next = w_pop ? w_fifo_dout : r_evt;

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            r_state   <= ST_IDLE;
            r_evt     <= '0;
            r_ok_seen <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_evt   <= w_evt_next;
            if (w_state_next == ST_IDLE || w_state_next == ST_ABORT) begin
                r_ok_seen <= 1'b0;
            end else if (w_ok && (r_state == ST_HDR || r_state == ST_DATA)) begin
                r_ok_seen <= 1'b1;
            end
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_waiting) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            r_csof_n     <= 1'b1;
            r_ceof_n     <= 1'b1;
            r_cd         <= '0;
            r_rdy_n      <= 1'b1;
            r_dsc_n      <= 1'b1;
            r_busy       <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_timeout <= 1'b0;
        end else begin
            r_csof_n     <= 1'b1;
            r_ceof_n     <= 1'b1;
            r_cd         <= '0;
            r_rdy_n      <= 1'b1;
            r_dsc_n      <= 1'b1;
            r_tx_done    <= 1'b0;
            r_tx_timeout <= 1'b0;
            r_busy       <= (w_state_next != ST_IDLE);
            unique case (w_state_next)
                ST_HDR: begin
                    r_cd     <= make_word0(w_evt_next.code);
                    r_csof_n <= 1'b0;
                    r_rdy_n  <= 1'b0;
                end
                ST_DATA: begin
                    r_cd     <= w_evt_next.data;
                    r_ceof_n <= 1'b0;
                    r_rdy_n  <= 1'b0;
                end
                ST_ABORT: begin
                    r_dsc_n      <= 1'b0;
                    r_tx_timeout <= 1'b1;
                end
                ST_IDLE: begin
                    r_tx_done <= (r_state == ST_WAIT_OK);
                end
                default: begin
                end
            endcase
        end
    end

    assign trn_csof_n     = r_csof_n;
    assign trn_ceof_n     = r_ceof_n;
    assign trn_cd         = r_cd;
    assign trn_csrc_rdy_n = r_rdy_n;
    assign trn_csrc_dsc_n = r_dsc_n;
    assign tx_busy        = r_busy;
    assign tx_done        = r_tx_done;
    assign tx_timeout     = r_tx_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sata_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sata_ctrl_tx
// Brief    : Directed self-checking bench for sata_ctrl_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sata_ctrl_tx;

    logic        phyclk = 1'b0;
    logic        phyreset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [3:0]  ev_code = 4'h0;
    logic [31:0] ev_data = 32'h0;
    logic        trn_csof_n;
    logic        trn_ceof_n;
    logic [31:0] trn_cd;
    logic        trn_csrc_rdy_n;
    logic        trn_csrc_dsc_n;
    logic        trn_cdst_rdy_n = 1'b1;
    logic        trn_cdst_dsc_n = 1'b1;
    logic        trn_cdst_lock_n = 1'b1;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_timeout;

    int checks = 0;
    int errors = 0;

    sata_ctrl_tx #(
        .C_FIFO_DEPTH (4),
        .C_TIMEOUT    (16)
    ) dut (
        .phyclk          (phyclk),
        .phyreset        (phyreset),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_code         (ev_code),
        .ev_data         (ev_data),
        .trn_csof_n      (trn_csof_n),
        .trn_ceof_n      (trn_ceof_n),
        .trn_cd          (trn_cd),
        .trn_csrc_rdy_n  (trn_csrc_rdy_n),
        .trn_csrc_dsc_n  (trn_csrc_dsc_n),
        .trn_cdst_rdy_n  (trn_cdst_rdy_n),
        .trn_cdst_dsc_n  (trn_cdst_dsc_n),
        .trn_cdst_lock_n (trn_cdst_lock_n),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .tx_timeout      (tx_timeout)
    );

    always #5 phyclk = ~phyclk;

    task automatic tick();
        @(posedge phyclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [31:0] d);
        ev_valid = 1'b1;
        ev_code  = c;
        ev_data  = d;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic ack();
        trn_cdst_rdy_n = 1'b0;
        tick();
        trn_cdst_rdy_n = 1'b1;
    endtask

    task automatic ok();
        trn_cdst_dsc_n = 1'b0;
        tick();
        trn_cdst_dsc_n = 1'b1;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (trn_csrc_rdy_n !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, trn_csrc_rdy_n}, 32'h0);
    endtask

    // Serve one complete frame with prompt acks and ok, checking both words
    task automatic serve_frame(input string tag, input logic [3:0] c, input logic [31:0] d);
        wait_rdy({tag, "_rdy"});
        chk({tag, "_w0"}, trn_cd, {8'hC5, 20'h0, c});
        chk({tag, "_sof"}, {31'h0, trn_csof_n}, 32'h0);
        ack();
        chk({tag, "_w1"}, trn_cd, d);
        chk({tag, "_eof"}, {30'h0, trn_ceof_n, trn_csrc_rdy_n}, 32'h0);
        ack();
        chk({tag, "_waitok"}, {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h6);
        ok();
        chk({tag, "_done"}, {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h5);
        tick();
        chk({tag, "_gap"}, {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h4);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        phyreset = 1'b0;
        chk("rst_flags", {24'h0, trn_csof_n, trn_ceof_n, trn_csrc_rdy_n, trn_csrc_dsc_n,
                          tx_busy, tx_done, tx_timeout, ev_ready}, 32'h000000F1);
        chk("rst_cd", trn_cd, 32'h0);

        // Single event with exact latency and held words
        push(4'h3, 32'hDEADBEEF);
        chk("t1_pop_cycle", {31'h0, trn_csrc_rdy_n}, 32'h1);
        tick();
        chk("t1_w0", trn_cd, 32'hC5000003);
        chk("t1_w0_flags", {29'h0, trn_csof_n, trn_ceof_n, trn_csrc_rdy_n}, 32'h2);
        chk("t1_busy", {31'h0, tx_busy}, 32'h1);
        repeat (4) tick();
        chk("t1_w0_hold", trn_cd, 32'hC5000003);
        ack();
        chk("t1_w1", trn_cd, 32'hDEADBEEF);
        chk("t1_w1_flags", {29'h0, trn_csof_n, trn_ceof_n, trn_csrc_rdy_n}, 32'h4);
        repeat (4) tick();
        chk("t1_w1_hold", trn_cd, 32'hDEADBEEF);
        ack();
        chk("t1_waitok", {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h6);
        repeat (9) tick();
        chk("t1_waitok_hold", {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h6);
        ok();
        chk("t1_done", {30'h0, tx_busy, tx_done}, 32'h1);
        tick();
        chk("t1_done_once", {30'h0, tx_busy, tx_done}, 32'h0);

        // FIFO full while stalled in HDR on frame E0
        push(4'h0, 32'h0000E000);
        wait_rdy("t2_e0_hdr");
        for (int i = 0; i < 5; i++) begin
            ev_valid = 1'b1;
            ev_code  = 4'(i + 1);
            ev_data  = 32'hA0000000 + 32'(i + 1);
            chk($sformatf("t2_ready_%0d", i + 1), {31'h0, ev_ready}, (i < 4) ? 32'h1 : 32'h0);
            tick();
        end
        ev_valid = 1'b0;
        chk("t2_full_after", {31'h0, ev_ready}, 32'h0);
        serve_frame("t2_e0", 4'h0, 32'h0000E000);
        serve_frame("t2_e1", 4'h1, 32'hA0000001);
        serve_frame("t2_e2", 4'h2, 32'hA0000002);
        serve_frame("t2_e3", 4'h3, 32'hA0000003);
        serve_frame("t2_e4", 4'h4, 32'hA0000004);
        repeat (5) tick();
        chk("t2_no_fifth", {30'h0, tx_busy, trn_csrc_rdy_n}, 32'h1);

        // Ok pulse arrives while in HDR
        push(4'h7, 32'h12345678);
        wait_rdy("t3_hdr");
        ok();
        chk("t3_still_hdr", trn_cd, 32'hC5000007);
        ack();
        chk("t3_w1", trn_cd, 32'h12345678);
        ack();
        chk("t3_waitok", {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h6);
        tick();
        chk("t3_done", {30'h0, tx_busy, tx_done}, 32'h1);

        // Timeout in HDR, then the queued frame goes out
        repeat (3) tick();
        push(4'h9, 32'h0BAD0BAD);
        push(4'hA, 32'h600D600D);
        wait_rdy("t4_hdr");
        begin
            int n = 0;
            while (trn_csrc_rdy_n === 1'b0 && n < 40) begin
                n++;
                tick();
            end
            chk("t4_hdr_cycles", 32'(n), 32'd16);
        end
        chk("t4_abort", {29'h0, trn_csrc_dsc_n, tx_timeout, trn_csrc_rdy_n}, 32'h3);
        tick();
        chk("t4_abort_1cyc", {30'h0, trn_csrc_dsc_n, tx_timeout}, 32'h2);
        serve_frame("t4_next", 4'hA, 32'h600D600D);

        // Stray ack/ok pulses in IDLE must not advance the next frame
        repeat (3) tick();
        ack();
        ok();
        trn_cdst_rdy_n = 1'b0;
        trn_cdst_dsc_n = 1'b0;
        tick();
        trn_cdst_rdy_n = 1'b1;
        trn_cdst_dsc_n = 1'b1;
        chk("t5_idle", {30'h0, tx_busy, tx_done}, 32'h0);
        push(4'h5, 32'hCAFEF00D);
        wait_rdy("t5_hdr");
        repeat (3) tick();
        chk("t5_w0_hold", trn_cd, 32'hC5000005);
        ack();
        repeat (3) tick();
        chk("t5_w1_hold", {trn_cd[31:1], trn_ceof_n}, {31'h657F7806, 1'b0});
        ack();
        repeat (3) tick();
        chk("t5_need_ok", {29'h0, trn_csrc_rdy_n, tx_busy, tx_done}, 32'h6);
        ok();
        chk("t5_done", {30'h0, tx_busy, tx_done}, 32'h1);

        // Reset while in DATA with another event queued
        repeat (3) tick();
        push(4'hC, 32'h11111111);
        push(4'hD, 32'h22222222);
        wait_rdy("t6_hdr");
        ack();
        chk("t6_in_data", trn_cd, 32'h11111111);
        phyreset = 1'b1;
        tick();
        phyreset = 1'b0;
        chk("t6_rst_flags", {24'h0, trn_csof_n, trn_ceof_n, trn_csrc_rdy_n, trn_csrc_dsc_n,
                             tx_busy, tx_done, tx_timeout, ev_ready}, 32'h000000F1);
        chk("t6_rst_cd", trn_cd, 32'h0);
        repeat (6) tick();
        chk("t6_fifo_empty", {28'h0, tx_busy, tx_done, tx_timeout, trn_csrc_rdy_n}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sata_ctrl_tx.md
# sata_ctrl_tx

Link-layer transmitter for the trn_c control/status channel. Runs in the phyclk domain inside the SATA link and converts link events (frame status, error codes) into two-word trn_c frames for the system-side control consumer. It holds each word until the consumer's single-cycle ack pulse arrives, then waits for the completion ("ok") pulse before sending the next frame. Events queue in a small FIFO so the link never blocks on the host.

## Interface
Parameters:
- C_FIFO_DEPTH, 4: event FIFO depth; must be a power of 2, at least 2.
- C_TIMEOUT, 1024: phyclk cycles to wait for an ack or ok pulse before aborting.

Ports:
- phyclk  in  1: the single clock.
- phyreset  in  1: synchronous, active-high reset.
- ev_valid  in  1: event push request.
- ev_ready  out  1: high when the FIFO is not full.
- ev_code  in  4: event/error code.
- ev_data  in  32: event payload.
- trn_csof_n  out  1: start of frame, active low.
- trn_ceof_n  out  1: end of frame, active low.
- trn_cd  out  32: frame data.
- trn_csrc_rdy_n  out  1: word valid, active low.
- trn_csrc_dsc_n  out  1: source discard (abort), active low.
- trn_cdst_rdy_n  in  1: ack; a one-cycle low pulse per accepted word.
- trn_cdst_dsc_n  in  1: ok; a one-cycle low pulse per completed frame.
- trn_cdst_lock_n  in  1: unused; ignored.
- tx_busy  out  1: high when the FSM is not in IDLE.
- tx_done  out  1: one-cycle pulse on frame completion.
- tx_timeout  out  1: one-cycle pulse on abort.

## Operation
- Push: when ev_valid && ev_ready, {ev_code, ev_data} is written to the FIFO. A push and a pop in the same cycle are both allowed. A push attempted while full is dropped; ev_ready is low in that case.
- Frame format:
  - word0 = {8'hC5, 20'h0, code}.
  - word1 = data.
- FSM states: IDLE, HDR, DATA, WAIT_OK, ABORT.
- IDLE: if the FIFO is not empty, pop the entry into a holding register and go to HDR.
- HDR: drive trn_cd=word0, trn_csof_n=0, trn_csrc_rdy_n=0. An ack moves to DATA.
- DATA: drive trn_cd=word1, trn_ceof_n=0, trn_csrc_rdy_n=0. An ack moves to WAIT_OK.
- WAIT_OK: drive trn_csrc_rdy_n=1. An ok pulse, or an ok_seen already set, pulses tx_done, clears ok_seen and returns to IDLE.
- ok_seen: set by an ok pulse in HDR or DATA, including the same cycle as the DATA ack. An ok pulse in IDLE is ignored.
- Ack pulses outside HDR/DATA are ignored. One ack advances exactly one word.
- Timeout counter:
  - Cleared on every state entry; increments in HDR, DATA and WAIT_OK.
  - Reaching C_TIMEOUT-1 without the awaited pulse moves to ABORT.
  - Width is clog2(C_TIMEOUT)+1.
- ABORT: lasts one cycle. Drive trn_csrc_dsc_n=0 and trn_csrc_rdy_n=1, pulse tx_timeout, drop the frame, clear ok_seen, go to IDLE.
- Mid-operation reset: phyreset forces IDLE, empties the FIFO and returns all outputs to their reset values the next cycle. No discard is emitted.

## Timing
- Reset values:
  - trn_csof_n, trn_ceof_n, trn_csrc_rdy_n, trn_csrc_dsc_n = 1.
  - trn_cd = 0.
  - tx_busy, tx_done, tx_timeout = 0.
  - ev_ready = 1.
- All trn_c outputs are registered.
- Latency:
  - Push at cycle t (empty FIFO, IDLE): pop at t+1; word0 is presented at t+2.
  - Ack at cycle a: the next word, or rdy deasserted, is presented at a+1.
  - Ok at cycle k in WAIT_OK: tx_done pulses at k+1, and the next frame's word0 appears no earlier than k+3.
- Words are held stable, with rdy_n low, until acked; there is no minimum hold requirement.
- ev_ready is registered from the FIFO count. Full is asserted the cycle after the push that fills the FIFO.

## Structure
- Package sata_ctrl_pkg holds:
  - the state enum;
  - the word0 tag constant 8'hC5;
  - the event struct {code[3:0], data[31:0]}.
- Sub-module ctrl_evt_fifo: a synchronous FIFO, 36 bits wide, C_FIFO_DEPTH deep, with a pointer/count scheme.
- The top level holds the FSM, ok_seen and the timeout counter.

## Test plan
- Single event: code=4'h3, data=32'hDEADBEEF, ack 5 cycles after each word, ok 10 cycles after the last ack.
  - Expect trn_cd=32'hC5000003 with sof, then 32'hDEADBEEF with eof.
  - tx_done pulses once; the FSM returns to IDLE.
- FIFO full: push 5 events back to back while the FSM is stalled in HDR.
  - ev_ready drops after the 4th push; the 5th is dropped.
  - After acks and oks, exactly 4 frames are sent, in order.
- Ok before ack: ok pulse during HDR, then acks.
  - Expect WAIT_OK to exit on the cycle after entry, and tx_done to pulse.
- Timeout (C_TIMEOUT=16): no ack in HDR.
  - Expect ABORT at cycle 16 of HDR: trn_csrc_dsc_n low for 1 cycle, tx_timeout pulses.
  - The next queued frame then starts.
- Stray pulses: ack and ok pulses while in IDLE, then one event.
  - Expect the frame to still need two fresh acks and one fresh ok.
- Reset mid-DATA: assert phyreset for 1 cycle.
  - All outputs return to reset values next cycle; the FIFO is empty; no tx_done.
